mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM-stage access engine for the 16-bit pipeline, sitting between the EXE/MEM pipeline register and the MEM/WB register. It consumes the registered EXE/MEM control and data, runs a multi-cycle FSM against the external asynchronous SRAM, and stalls the upstream pipeline while the access is in flight. It also presents the selected write-back value, address and register op to MEM/WB. An optional build adds memory-mapped UART access.

## Interface
- SETUP_CYC, 1: cycles of address/data setup before the strobe (≥1).
- STROBE_CYC, 2: cycles the OE/WE strobe is held low (≥1).
- clk_50MHz  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- em_RAM_en  in  1  memory access requested by the instruction in MEM.
- em_RAM_op  in  1  1 = write, 0 = read.
- em_WB_DATA_op  in  2  write-back source select.
- em_REG_op  in  3  register-file op; passed through.
- em_IH, em_PC, em_ALU_data, em_RAM_WB_data  in  16 each  IH value, PC, ALU result/address, store data.
- em_WB_addr  in  4  destination register; passed through.
- ram_addr  out  18  SRAM address.
- ram_dq  inout  16  SRAM data bus.
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low.
- mem_stall  out  1  freezes PC through EXE/MEM when high.
- n_mw_WB_data  out  16  write-back value to MEM/WB.
- n_mw_WB_addr  out  4  equals em_WB_addr.
- n_mw_REG_op  out  3  equals em_REG_op.
- uart_rx_valid, uart_tx_ready  in  1 each  (UART build only) receive byte available, transmitter can accept.
- uart_rx_data  in  8  (UART build only).
- uart_rx_pop, uart_tx_push  out  1 each  (UART build only) one-cycle pulses.
- uart_tx_data  out  8  (UART build only).

## Operation
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE: on em_RAM_en=1 (SRAM target), latch ram_addr={2'b00,em_ALU_data}, go to SETUP; otherwise stay.
- SETUP: ram_ce_n=0; for a write, drive ram_dq=em_RAM_WB_data. After SETUP_CYC cycles, go to STROBE.
- STROBE: read holds ram_oe_n=0; write holds ram_we_n=0 with dq still driven. After STROBE_CYC cycles, go to DONE. A read captures ram_dq into rdata_q on the final STROBE edge.
- DONE: all strobes high, dq released to high-Z. Next state is unconditionally IDLE.
- mem_stall = em_RAM_en & (state != DONE), combinational. EXE/MEM advances on the DONE edge, so IDLE sees the next instruction one cycle later. Back-to-back accesses therefore never reuse a completed access.
- n_mw_WB_data mux on em_WB_DATA_op:
  - 00: em_ALU_data
  - 01: rdata_q
  - 10: em_PC
  - 11: em_IH
- ram_dq is high-Z in every state unless a write is in SETUP or STROBE.
- Reset values (applied on any clock edge with rst=0, including mid-access):
  - state: IDLE
  - ram_ce_n, ram_oe_n, ram_we_n: 1
  - ram_addr: 0
  - rdata_q: 0
  - ram_dq: high-Z
  - uart_rx_pop, uart_tx_push: 0
  - uart_tx_data: 0
  - setup/strobe counters: 0
- Reset mid-write: ram_we_n returns to 1 on the reset edge. The write's completion is undefined and must not be relied on.

## Timing
- SRAM access with em_RAM_en held: mem_stall is high for 1 + SETUP_CYC + STROBE_CYC cycles, then low for exactly one cycle (DONE). Defaults give 4 stall cycles and 5 cycles total.
- Non-memory instruction: mem_stall=0 in the same cycle, with zero added latency.
- ram_addr is stable from the first SETUP cycle through DONE.
- rdata_q is valid from DONE onward, until the next read's final STROBE edge.
- Outputs n_mw_* are combinational from em_* and rdata_q. MEM/WB samples them only when mem_stall=0.

## Configuration
- UART_MMIO_EN defined: UART ports exist, and addresses 0xBF00/0xBF01 bypass SRAM (no CE/OE/WE activity).
  - Read 0xBF00: rdata_q={8'h00,uart_rx_data}, uart_rx_pop pulses one cycle only if uart_rx_valid=1, then IDLE→DONE.
  - Read 0xBF01: rdata_q={14'b0,uart_rx_valid,uart_tx_ready}, IDLE→DONE.
  - Write 0xBF00: wait in IDLE (stalling) until uart_tx_ready=1. Then pulse uart_tx_push with uart_tx_data=em_RAM_WB_data[7:0], and go IDLE→DONE.
  - Write 0xBF01: ignored, IDLE→DONE.
- UART_MMIO_EN undefined: UART ports absent, and every address, including 0xBFxx, goes to SRAM.

## Test plan
- Read 0x1234, SRAM model returns 0xBEEF, WB_DATA_op=01, defaults → mem_stall high 4 cycles; ram_oe_n low cycles 3–4; n_mw_WB_data=0xBEEF in DONE.
- Write 0x00FF data 0xA5A5 → ram_we_n low 2 cycles, dq=0xA5A5 from SETUP through STROBE, high-Z in DONE; model holds 0xA5A5.
- Back-to-back write 0x0010 then read 0x0010 → second access starts the cycle after DONE and reads back the written value; no strobe overlap.
- Assert rst=0 during STROBE of a write → next edge: all strobes 1, dq high-Z, state IDLE, mem_stall follows em_RAM_en.
- Non-memory op, WB_DATA_op=10, em_PC=0x0042 → mem_stall=0, n_mw_WB_data=0x0042 the same cycle.
- UART_MMIO_EN: write 0xBF00 data 0x0041 with uart_tx_ready=0 for 3 cycles → stall until ready; then one uart_tx_push pulse with tx_data=0x41; no SRAM strobes.

Source files
------------

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Brief    : EXE/MEM inputs, SRAM control and MEM/WB outputs of the MEM stage.
// Revision : 1.0
// ============================================================================
interface mem_access_if;
  logic        em_RAM_en;
  logic        em_RAM_op;
  logic [1:0]  em_WB_DATA_op;
  logic [2:0]  em_REG_op;
  logic [15:0] em_IH;
  logic [15:0] em_PC;
  logic [15:0] em_ALU_data;
  logic [15:0] em_RAM_WB_data;
  logic [3:0]  em_WB_addr;
  logic [17:0] ram_addr;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic        mem_stall;
  logic [15:0] n_mw_WB_data;
  logic [3:0]  n_mw_WB_addr;
  logic [2:0]  n_mw_REG_op;
`ifdef UART_MMIO_EN
  logic        uart_rx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_pop;
  logic        uart_tx_push;
  logic [7:0]  uart_tx_data;
`endif

  modport master (
    input  em_RAM_en, em_RAM_op, em_WB_DATA_op, em_REG_op, em_IH, em_PC,
           em_ALU_data, em_RAM_WB_data, em_WB_addr,
    output ram_addr, ram_ce_n, ram_oe_n, ram_we_n, mem_stall,
           n_mw_WB_data, n_mw_WB_addr, n_mw_REG_op
`ifdef UART_MMIO_EN
    , input  uart_rx_valid, uart_tx_ready, uart_rx_data
    , output uart_rx_pop, uart_tx_push, uart_tx_data
`endif
  );

  modport slave (
    output em_RAM_en, em_RAM_op, em_WB_DATA_op, em_REG_op, em_IH, em_PC,
           em_ALU_data, em_RAM_WB_data, em_WB_addr,
    input  ram_addr, ram_ce_n, ram_oe_n, ram_we_n, mem_stall,
           n_mw_WB_data, n_mw_WB_addr, n_mw_REG_op
`ifdef UART_MMIO_EN
    , output uart_rx_valid, uart_tx_ready, uart_rx_data
    , input  uart_rx_pop, uart_tx_push, uart_tx_data
`endif
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : MEM-stage SRAM access FSM with pipeline stall and write-back mux.
//            Define UART_MMIO_EN to map the UART at 0xBF00/0xBF01.
// Revision : 1.0
// ============================================================================
module mem_access_stage #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  wire logic        clk_50MHz,
  input  wire logic        rst,
  mem_access_if.master     bus,
  // The tri-state bus stays a plain port so it resolves at the top level
  inout  wire logic [15:0] ram_dq
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  logic [17:0] r_ram_addr;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_is_write;
  logic        r_dq_oe;
  logic [15:0] r_dq_out;
  logic [15:0] r_rdata;
  logic [7:0]  r_setup_cnt;
  logic [7:0]  r_strobe_cnt;
  logic        w_uart_hit;

`ifdef UART_MMIO_EN
  logic        r_rx_pop;
  logic        r_tx_push;
  logic [7:0]  r_tx_data;

  assign w_uart_hit       = (bus.em_ALU_data[15:1] == 15'h5F80);
  assign bus.uart_rx_pop  = r_rx_pop;
  assign bus.uart_tx_push = r_tx_push;
  assign bus.uart_tx_data = r_tx_data;
`else
  assign w_uart_hit = 1'b0;
`endif

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ram_addr   <= 18'd0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_is_write   <= 1'b0;
      r_dq_oe      <= 1'b0;
      r_dq_out     <= 16'd0;
      r_rdata      <= 16'd0;
      r_setup_cnt  <= 8'd0;
      r_strobe_cnt <= 8'd0;
`ifdef UART_MMIO_EN
      r_rx_pop     <= 1'b0;
      r_tx_push    <= 1'b0;
      r_tx_data    <= 8'd0;
`endif
    end else begin
`ifdef UART_MMIO_EN
      r_rx_pop  <= 1'b0;
      r_tx_push <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.em_RAM_en && !w_uart_hit) begin
            r_ram_addr  <= {2'b00, bus.em_ALU_data};
            r_is_write  <= bus.em_RAM_op;
            r_ce_n      <= 1'b0;
            r_dq_oe     <= bus.em_RAM_op;
            r_dq_out    <= bus.em_RAM_WB_data;
            r_setup_cnt <= 8'd0;
            r_state     <= S_SETUP;
          end
`ifdef UART_MMIO_EN
          else if (bus.em_RAM_en) begin
            // UART accesses finish straight from IDLE; a TX write waits for ready here
            if (!bus.em_ALU_data[0]) begin
              if (!bus.em_RAM_op) begin
                r_rdata  <= {8'h00, bus.uart_rx_data};
                r_rx_pop <= bus.uart_rx_valid;
                r_state  <= S_DONE;
              end else if (bus.uart_tx_ready) begin
                r_tx_push <= 1'b1;
                r_tx_data <= bus.em_RAM_WB_data[7:0];
                r_state   <= S_DONE;
              end
            end else begin
              if (!bus.em_RAM_op)
                r_rdata <= {14'b0, bus.uart_rx_valid, bus.uart_tx_ready};
              r_state <= S_DONE;
            end
          end
`endif
        end
        S_SETUP: begin
          if (r_setup_cnt == 8'(SETUP_CYC - 1)) begin
            r_setup_cnt  <= 8'd0;
            r_strobe_cnt <= 8'd0;
            r_oe_n       <= r_is_write;
            r_we_n       <= !r_is_write;
            r_state      <= S_STROBE;
          end else begin
            r_setup_cnt <= r_setup_cnt + 8'd1;
          end
        end
        S_STROBE: begin
          if (r_strobe_cnt == 8'(STROBE_CYC - 1)) begin
            r_strobe_cnt <= 8'd0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_dq_oe      <= 1'b0;
            if (!r_is_write)
              r_rdata <= ram_dq;
            r_state      <= S_DONE;
          end else begin
            r_strobe_cnt <= r_strobe_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_dq       = r_dq_oe ? r_dq_out : 16'hzzzz;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_ce_n = r_ce_n;
  assign bus.ram_oe_n = r_oe_n;
  assign bus.ram_we_n = r_we_n;

  // Stall drops only in DONE so EXE/MEM advances on the DONE edge
  assign bus.mem_stall = bus.em_RAM_en && (r_state != S_DONE);

  always_comb begin
    case (bus.em_WB_DATA_op)
      2'b00:   bus.n_mw_WB_data = bus.em_ALU_data;
      2'b01:   bus.n_mw_WB_data = r_rdata;
      2'b10:   bus.n_mw_WB_data = bus.em_PC;
      default: bus.n_mw_WB_data = bus.em_IH;
    endcase
  end

  assign bus.n_mw_WB_addr = bus.em_WB_addr;
  assign bus.n_mw_REG_op  = bus.em_REG_op;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Directed self-checking bench for mem_access_stage with an SRAM model.
// Revision : 1.0
// ============================================================================
module tb_mem_access_stage;
  logic        clk_50MHz;
  logic        rst;
  wire  [15:0] ram_dq;
  int          n_checks;
  int          n_fail;

  mem_access_if bus ();

  mem_access_stage #(.SETUP_CYC(1), .STROBE_CYC(2)) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .bus       (bus),
    .ram_dq    (ram_dq)
  );

  initial clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  // Asynchronous SRAM model; 0x1234 is preloaded with 0xBEEF during reset
  logic [15:0] sram [0:65535];
  wire         w_sram_rd = !bus.ram_ce_n && !bus.ram_oe_n && bus.ram_we_n;
  assign ram_dq = w_sram_rd ? sram[bus.ram_addr[15:0]] : 16'hzzzz;

  always @(posedge clk_50MHz) begin
    if (!rst)
      sram[16'h1234] <= 16'hBEEF;
    else if (!bus.ram_ce_n && !bus.ram_we_n)
      sram[bus.ram_addr[15:0]] <= ram_dq;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
    check("no_strobe_overlap", 32'(bus.ram_oe_n | bus.ram_we_n), 32'd1);
  endtask

  task automatic set_op(input logic en, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] wbop);
    bus.em_RAM_en      = en;
    bus.em_RAM_op      = wr;
    bus.em_ALU_data    = addr;
    bus.em_RAM_WB_data = wdata;
    bus.em_WB_DATA_op  = wbop;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.em_REG_op  = 3'd0;
    bus.em_IH      = 16'd0;
    bus.em_PC      = 16'd0;
    bus.em_WB_addr = 4'd0;
`ifdef UART_MMIO_EN
    bus.uart_rx_valid = 1'b0;
    bus.uart_tx_ready = 1'b0;
    bus.uart_rx_data  = 8'd0;
`endif
    set_op(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b01);
    tick();
    tick();

    // Reset state
    check("rst_ce_n",   32'(bus.ram_ce_n), 32'd1);
    check("rst_oe_n",   32'(bus.ram_oe_n), 32'd1);
    check("rst_we_n",   32'(bus.ram_we_n), 32'd1);
    check("rst_addr",   32'(bus.ram_addr), 32'd0);
    check("rst_stall",  32'(bus.mem_stall), 32'd0);
    check("rst_rdata",  32'(bus.n_mw_WB_data), 32'd0);
    rst = 1'b1;
    tick();

    // Non-memory ops: zero latency, mux sources
    bus.em_PC = 16'h0042; bus.em_IH = 16'h7777; bus.em_WB_addr = 4'd5; bus.em_REG_op = 3'd3;
    set_op(1'b0, 1'b0, 16'h1111, 16'h0000, 2'b10);
    check("nomem_stall", 32'(bus.mem_stall), 32'd0);
    check("wb_pc",       32'(bus.n_mw_WB_data), 32'h0042);
    check("wb_addr",     32'(bus.n_mw_WB_addr), 32'd5);
    check("reg_op",      32'(bus.n_mw_REG_op), 32'd3);
    set_op(1'b0, 1'b0, 16'h1111, 16'h0000, 2'b11);
    check("wb_ih",       32'(bus.n_mw_WB_data), 32'h7777);
    set_op(1'b0, 1'b0, 16'h1111, 16'h0000, 2'b00);
    check("wb_alu",      32'(bus.n_mw_WB_data), 32'h1111);
    tick();

    // Read 0x1234 -> 0xBEEF
    set_op(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b01);
    check("rd_c1_stall", 32'(bus.mem_stall), 32'd1);
    tick();
    check("rd_c2_stall", 32'(bus.mem_stall), 32'd1);
    check("rd_c2_ce_n",  32'(bus.ram_ce_n), 32'd0);
    check("rd_c2_oe_n",  32'(bus.ram_oe_n), 32'd1);
    check("rd_addr",     32'(bus.ram_addr), 32'h01234);
    tick();
    check("rd_c3_oe_n",  32'(bus.ram_oe_n), 32'd0);
    check("rd_c3_stall", 32'(bus.mem_stall), 32'd1);
    tick();
    check("rd_c4_oe_n",  32'(bus.ram_oe_n), 32'd0);
    check("rd_c4_stall", 32'(bus.mem_stall), 32'd1);
    check("rd_c4_addr",  32'(bus.ram_addr), 32'h01234);
    tick();
    check("rd_done_stall", 32'(bus.mem_stall), 32'd0);
    check("rd_done_oe_n",  32'(bus.ram_oe_n), 32'd1);
    check("rd_done_ce_n",  32'(bus.ram_ce_n), 32'd1);
    check("rd_done_data",  32'(bus.n_mw_WB_data), 32'hBEEF);
    tick();

    // Write 0x00FF <- 0xA5A5
    set_op(1'b1, 1'b1, 16'h00FF, 16'hA5A5, 2'b00);
    check("wr_c1_stall", 32'(bus.mem_stall), 32'd1);
    tick();
    check("wr_c2_ce_n",  32'(bus.ram_ce_n), 32'd0);
    check("wr_c2_we_n",  32'(bus.ram_we_n), 32'd1);
    check("wr_c2_dq",    32'(ram_dq), 32'hA5A5);
    tick();
    check("wr_c3_we_n",  32'(bus.ram_we_n), 32'd0);
    check("wr_c3_dq",    32'(ram_dq), 32'hA5A5);
    tick();
    check("wr_c4_we_n",  32'(bus.ram_we_n), 32'd0);
    check("wr_c4_dq",    32'(ram_dq), 32'hA5A5);
    tick();
    check("wr_done_we_n",  32'(bus.ram_we_n), 32'd1);
    check("wr_done_stall", 32'(bus.mem_stall), 32'd0);
    check("wr_done_dq_released", 32'(ram_dq !== 16'hA5A5), 32'd1);
    check("wr_model",      32'(sram[16'h00FF]), 32'hA5A5);
    set_op(1'b1, 1'b1, 16'h00FF, 16'hA5A5, 2'b01);
    check("rdata_held_after_write", 32'(bus.n_mw_WB_data), 32'hBEEF);
    tick();

    // Back-to-back write 0x0010 then read 0x0010
    set_op(1'b1, 1'b1, 16'h0010, 16'h5A5A, 2'b00);
    tick(); tick(); tick(); tick();
    check("b2b_wr_done_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    set_op(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b01);
    check("b2b_rd_start_stall", 32'(bus.mem_stall), 32'd1);
    check("b2b_rd_idle_ce_n",   32'(bus.ram_ce_n), 32'd1);
    tick();
    check("b2b_rd_setup_ce_n",  32'(bus.ram_ce_n), 32'd0);
    tick(); tick(); tick();
    check("b2b_rd_done_stall",  32'(bus.mem_stall), 32'd0);
    check("b2b_rd_data",        32'(bus.n_mw_WB_data), 32'h5A5A);
    tick();

    // Reset during STROBE of a write
    set_op(1'b1, 1'b1, 16'h0020, 16'h1111, 2'b00);
    tick(); tick();
    check("rstw_strobe_we_n", 32'(bus.ram_we_n), 32'd0);
    rst = 1'b0;
    tick();
    check("rstw_we_n",  32'(bus.ram_we_n), 32'd1);
    check("rstw_ce_n",  32'(bus.ram_ce_n), 32'd1);
    check("rstw_oe_n",  32'(bus.ram_oe_n), 32'd1);
    check("rstw_addr",  32'(bus.ram_addr), 32'd0);
    check("rstw_dq_released", 32'(ram_dq !== 16'h1111), 32'd1);
    check("rstw_stall_en", 32'(bus.mem_stall), 32'd1);
    set_op(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b01);
    check("rstw_stall_dis", 32'(bus.mem_stall), 32'd0);
    check("rstw_rdata", 32'(bus.n_mw_WB_data), 32'd0);
    rst = 1'b1;
    tick();

`ifdef UART_MMIO_EN
    // UART TX write waits for ready, no SRAM activity
    set_op(1'b1, 1'b1, 16'hBF00, 16'h0041, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("uart_wait_stall", 32'(bus.mem_stall), 32'd1);
      check("uart_wait_push",  32'(bus.uart_tx_push), 32'd0);
      check("uart_wait_ce_n",  32'(bus.ram_ce_n), 32'd1);
    end
    bus.uart_tx_ready = 1'b1;
    tick();
    check("uart_push",     32'(bus.uart_tx_push), 32'd1);
    check("uart_tx_data",  32'(bus.uart_tx_data), 32'h41);
    check("uart_done_stall", 32'(bus.mem_stall), 32'd0);
    check("uart_ce_n",     32'(bus.ram_ce_n), 32'd1);
    check("uart_we_n",     32'(bus.ram_we_n), 32'd1);
    tick();
    set_op(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    check("uart_push_pulse", 32'(bus.uart_tx_push), 32'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
